// File: rtl/vbuf_pkg.sv
// Shared definitions for the vector buffer file, its read arbiter and the
// store unit.
//   arb_state_t : read-port arbiter state
//   tile_t      : one tile as VBUF_TILE_ELEMS elements of VBUF_DATA_WIDTH bits
//   idx_width() : width of an index into n requesters (at least 1 bit)
package vbuf_pkg;

    localparam int VBUF_DATA_WIDTH = 8;
    localparam int VBUF_TILE_WIDTH = 256;
    localparam int VBUF_TILE_ELEMS = VBUF_TILE_WIDTH / VBUF_DATA_WIDTH;
    localparam int VBUF_ID_WIDTH   = 5;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef logic [VBUF_TILE_ELEMS-1:0][VBUF_DATA_WIDTH-1:0] tile_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vbuf_read_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   elig        : eligible requesters
//   rr_ptr      : index with highest priority this round
//   pick_onehot : one-hot of the first eligible index at or after rr_ptr
//   pick_idx    : binary index of that pick
//   pick_valid  : at least one requester is eligible
module vbuf_read_arbiter_rr_pick
    import vbuf_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  pick_onehot,
    output logic [IW-1:0] pick_idx,
    output logic          pick_valid
);

    int cand;

    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        pick_valid  = 1'b0;
        cand        = 0;
        // Scan rr_ptr, rr_ptr+1, ... wrapping; rr_ptr is always < N so a
        // single subtraction is enough for the wrap.
        for (int k = 0; k < N; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!pick_valid && elig[cand]) begin
                pick_valid        = 1'b1;
                pick_onehot[cand] = 1'b1;
                pick_idx          = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/vbuf_read_arbiter.sv
// Round-robin arbiter sharing the vector buffer file read port among
// NUM_REQ tile readers (index 0 = store unit). One grant is held per tile
// read until buf_read_done; the returned tile is snapshotted per requester
// and a one-cycle req_done pulse is issued.
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_en/req_id : level request and buffer id per requester
//   req_data      : registered tile snapshot per requester
//   req_done      : one-cycle pulse, req_data[i] freshly valid
//   buf_read_*    : read port to the vector buffer file
//   grant, busy   : current owner (one-hot) and busy flag
module vbuf_read_arbiter
    import vbuf_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = VBUF_DATA_WIDTH,
    parameter int TILE_WIDTH = VBUF_TILE_WIDTH,
    parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
    parameter int ID_WIDTH   = VBUF_ID_WIDTH
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [NUM_REQ-1:0]                              req_en,
    input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]                req_id,
    output logic [NUM_REQ-1:0][TILE_ELEMS-1:0][DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                              req_done,
    output logic                                            buf_read_en,
    output logic [ID_WIDTH-1:0]                             buf_read_id,
    input  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0]           buf_read_data,
    input  logic                                            buf_read_done,
    output logic [NUM_REQ-1:0]                              grant,
    output logic                                            busy
);

    localparam int IW = idx_width(NUM_REQ);

    arb_state_t                state_q, state_d;
    logic [NUM_REQ-1:0]        grant_q, grant_d;
    logic [IW-1:0]             gidx_q, gidx_d;
    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic                      rd_en_q, rd_en_d;
    logic [ID_WIDTH-1:0]       rd_id_q, rd_id_d;

    logic [NUM_REQ-1:0]        mask;
    logic [NUM_REQ-1:0]        elig;
    logic [NUM_REQ-1:0]        pick_onehot;
    logic [IW-1:0]             pick_idx;
    logic                      pick_valid;
    logic                      capture;

    assign elig    = req_en & ~mask;
    // Completion only counts while a read is actually outstanding.
    assign capture = (state_q == ARB_BUSY) && buf_read_done;

    vbuf_read_arbiter_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .elig        (elig),
        .rr_ptr      (rr_ptr_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_valid  (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        rd_en_d  = rd_en_q;
        rd_id_d  = rd_id_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_BUSY;
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    rd_en_d = 1'b1;
                    rd_id_d = req_id[pick_idx];
                end
            end
            ARB_BUSY: begin
                // req_en of the owner is ignored here: an abandoned read
                // still runs to completion and delivers its done.
                if (buf_read_done) begin
                    state_d  = ARB_IDLE;
                    grant_d  = '0;
                    rd_en_d  = 1'b0;
                    rr_ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            rd_en_q  <= 1'b0;
            rd_id_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            rd_en_q  <= rd_en_d;
            rd_id_q  <= rd_id_d;
        end
    end

    assign buf_read_en = rd_en_q;
    assign buf_read_id = rd_id_q;
    assign grant       = grant_q;
    assign busy        = (state_q == ARB_BUSY);

    // Per-requester snapshot, done pulse and mask counter.
    logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] data_q     [NUM_REQ];
    logic                                  done_q     [NUM_REQ];
    logic [1:0]                            mask_cnt_q [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q[gi]     <= '0;
                done_q[gi]     <= 1'b0;
                mask_cnt_q[gi] <= 2'd0;
            end else begin
                done_q[gi] <= capture && grant_q[gi];
                if (capture && grant_q[gi]) begin
                    data_q[gi] <= buf_read_data;
                end
                // Mask covers the done cycle and the one after, so a
                // requester whose enable drops up to 2 cycles late is not
                // served the same tile twice.
                if (capture && grant_q[gi]) begin
                    mask_cnt_q[gi] <= 2'd2;
                end else if (mask_cnt_q[gi] != 2'd0) begin
                    mask_cnt_q[gi] <= mask_cnt_q[gi] - 2'd1;
                end
            end
        end

        assign mask[gi]     = (mask_cnt_q[gi] != 2'd0);
        assign req_data[gi] = data_q[gi];
        assign req_done[gi] = done_q[gi];
    end

endmodule

// File: tb/tb_vbuf_read_arbiter.sv
module tb_vbuf_read_arbiter;
    import vbuf_pkg::*;

    localparam int NR  = 3;
    localparam int IDW = VBUF_ID_WIDTH;
    localparam int TE  = VBUF_TILE_ELEMS;
    localparam int DW  = VBUF_DATA_WIDTH;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic [NR-1:0]                 req_en = '0;
    logic [NR-1:0][IDW-1:0]        req_id = '0;
    logic [NR-1:0][TE-1:0][DW-1:0] req_data;
    logic [NR-1:0]                 req_done;
    logic                          buf_read_en;
    logic [IDW-1:0]                buf_read_id;
    tile_t                         buf_read_data = '0;
    logic                          buf_read_done = 1'b0;
    logic [NR-1:0]                 grant;
    logic                          busy;

    int    total = 0;
    int    bad   = 0;
    tile_t exp_data [NR];

    vbuf_read_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .TILE_WIDTH (VBUF_TILE_WIDTH),
        .TILE_ELEMS (TE),
        .ID_WIDTH   (IDW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_en        (req_en),
        .req_id        (req_id),
        .req_data      (req_data),
        .req_done      (req_done),
        .buf_read_en   (buf_read_en),
        .buf_read_id   (buf_read_id),
        .buf_read_data (buf_read_data),
        .buf_read_done (buf_read_done),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic tile_t make_tile(input logic [7:0] base);
        tile_t t;
        for (int e = 0; e < TE; e++) begin
            t[e] = base + 8'(e);
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        req_en        = '0;
        buf_read_done = 1'b0;
        for (int i = 0; i < NR; i++) exp_data[i] = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (buf_read_en !== 1'b0) begin bad++; $display("FAIL reset_en: got %0b want 0", buf_read_en); end
        total++; if (buf_read_id !== 5'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", buf_read_id); end
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL reset_grant: got %b want 000", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (req_done !== 3'b000) begin bad++; $display("FAIL reset_done: got %b want 000", req_done); end
        for (int i = 0; i < NR; i++) begin
            total++; if (req_data[i] !== exp_data[i]) begin bad++; $display("FAIL reset_data[%0d]: got %h want %h", i, req_data[i], exp_data[i]); end
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_single();
        tile_t t;
        apply_reset();
        t         = make_tile(8'h00);
        req_id[0] = 5'd7;
        req_en    = 3'b001;
        tick();
        total++; if (buf_read_en !== 1'b1) begin bad++; $display("FAIL single_en: got %0b want 1", buf_read_en); end
        total++; if (buf_read_id !== 5'd7) begin bad++; $display("FAIL single_id: got %0d want 7", buf_read_id); end
        total++; if (grant !== 3'b001) begin bad++; $display("FAIL single_grant: got %b want 001", grant); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b want 1", busy); end
        tick();
        total++; if (req_done !== 3'b000) begin bad++; $display("FAIL single_early_done: got %b want 000", req_done); end
        tick();
        buf_read_data = t;
        buf_read_done = 1'b1;
        tick();
        buf_read_done = 1'b0;
        exp_data[0]   = t;
        total++; if (req_done !== 3'b001) begin bad++; $display("FAIL single_done: got %b want 001", req_done); end
        total++; if (req_data[0] !== exp_data[0]) begin bad++; $display("FAIL single_data: got %h want %h", req_data[0], exp_data[0]); end
        total++; if (grant !== 3'b000 || buf_read_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_release: got grant=%b en=%0b busy=%0b want 000/0/0", grant, buf_read_en, busy); end
        $display("single: req 0 id 7 done");
        // req_en[0] still high through the two masked cycles
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (req_done !== 3'b000) begin bad++; $display("FAIL single_pulse_once[%0d]: got %b want 000", c, req_done); end
            total++; if (buf_read_en !== 1'b0 || grant !== 3'b000) begin bad++; $display("FAIL single_no_regrant[%0d]: got en=%0b grant=%b want 0/000", c, buf_read_en, grant); end
        end
        req_en = 3'b000;
        tick();
        total++; if (buf_read_en !== 1'b0) begin bad++; $display("FAIL single_idle: got %0b want 0", buf_read_en); end
    endtask

    // Contention plus snapshot stability: every entry is checked against
    // its own last tile both during each read and after each done.
    task automatic test_contention();
        logic [NR-1:0] exp_g;
        int            g;
        tile_t         t;
        apply_reset();
        req_id[0] = 5'd1;
        req_id[1] = 5'd2;
        req_id[2] = 5'd3;
        req_en    = 3'b111;
        for (int k = 0; k < 4; k++) begin
            g     = k % NR;
            exp_g = 3'b001 << g;
            t     = make_tile(8'(8'h20 * (k + 1)));
            tick();
            total++; if (grant !== exp_g) begin bad++; $display("FAIL contention_grant[%0d]: got %b want %b", k, grant, exp_g); end
            total++; if (buf_read_id !== req_id[g]) begin bad++; $display("FAIL contention_id[%0d]: got %0d want %0d", k, buf_read_id, req_id[g]); end
            for (int i = 0; i < NR; i++) begin
                total++; if (req_data[i] !== exp_data[i]) begin bad++; $display("FAIL snapshot_during[%0d][%0d]: got %h want %h", k, i, req_data[i], exp_data[i]); end
            end
            tick();
            buf_read_data = t;
            buf_read_done = 1'b1;
            tick();
            buf_read_done = 1'b0;
            exp_data[g]   = t;
            total++; if (req_done !== exp_g) begin bad++; $display("FAIL contention_done[%0d]: got %b want %b", k, req_done, exp_g); end
            for (int i = 0; i < NR; i++) begin
                total++; if (req_data[i] !== exp_data[i]) begin bad++; $display("FAIL snapshot_after[%0d][%0d]: got %h want %h", k, i, req_data[i], exp_data[i]); end
            end
            $display("contention: grant %0d to req %0d done", k, g);
        end
        req_en = 3'b000;
        repeat (3) tick();
    endtask

    task automatic test_abandon();
        tile_t t;
        apply_reset();
        t         = make_tile(8'h60);
        req_id[2] = 5'd9;
        req_en    = 3'b100;
        tick();
        total++; if (grant !== 3'b100) begin bad++; $display("FAIL abandon_grant: got %b want 100", grant); end
        req_en = 3'b000;
        tick();
        total++; if (buf_read_en !== 1'b1 || grant !== 3'b100) begin bad++; $display("FAIL abandon_hold: got en=%0b grant=%b want 1/100", buf_read_en, grant); end
        buf_read_data = t;
        buf_read_done = 1'b1;
        tick();
        buf_read_done = 1'b0;
        exp_data[2]   = t;
        total++; if (req_done !== 3'b100) begin bad++; $display("FAIL abandon_done: got %b want 100", req_done); end
        total++; if (req_data[2] !== exp_data[2]) begin bad++; $display("FAIL abandon_data: got %h want %h", req_data[2], exp_data[2]); end
        $display("abandon: req 2 read completed after drop");
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (grant !== 3'b000 || buf_read_en !== 1'b0) begin bad++; $display("FAIL abandon_no_regrant[%0d]: got grant=%b en=%0b want 000/0", c, grant, buf_read_en); end
        end
    endtask

    // Runs straight after test_abandon so req_data[2] holds a known tile.
    task automatic test_spurious();
        buf_read_data = make_tile(8'hE0);
        buf_read_done = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (req_done !== 3'b000) begin bad++; $display("FAIL spurious_done[%0d]: got %b want 000", c, req_done); end
            total++; if (busy !== 1'b0 || buf_read_en !== 1'b0) begin bad++; $display("FAIL spurious_busy[%0d]: got busy=%0b en=%0b want 0/0", c, busy, buf_read_en); end
            for (int i = 0; i < NR; i++) begin
                total++; if (req_data[i] !== exp_data[i]) begin bad++; $display("FAIL spurious_data[%0d][%0d]: got %h want %h", c, i, req_data[i], exp_data[i]); end
            end
        end
        buf_read_done = 1'b0;
        $display("spurious: idle done ignored");
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        req_id[0] = 5'd11;
        req_id[1] = 5'd4;
        req_id[2] = 5'd6;
        // Complete a read for req 1 so the pointer moves to 2.
        req_en = 3'b010;
        tick();
        total++; if (grant !== 3'b010) begin bad++; $display("FAIL midrst_grant1: got %b want 010", grant); end
        buf_read_data = make_tile(8'hA0);
        buf_read_done = 1'b1;
        tick();
        buf_read_done = 1'b0;
        req_en        = 3'b100;
        tick();
        total++; if (grant !== 3'b100 || buf_read_id !== 5'd6) begin bad++; $display("FAIL midrst_grant2: got grant=%b id=%0d want 100/6", grant, buf_read_id); end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) exp_data[i] = '0;
        total++; if (buf_read_en !== 1'b0 || grant !== 3'b000 || busy !== 1'b0 || buf_read_id !== 5'd0) begin bad++; $display("FAIL midrst_async: got en=%0b grant=%b busy=%0b id=%0d want 0/000/0/0", buf_read_en, grant, busy, buf_read_id); end
        for (int i = 0; i < NR; i++) begin
            total++; if (req_data[i] !== exp_data[i]) begin bad++; $display("FAIL midrst_data[%0d]: got %h want %h", i, req_data[i], exp_data[i]); end
        end
        req_en        = 3'b000;
        buf_read_data = make_tile(8'hC0);
        @(negedge clk);
        rst_n         = 1'b1;
        buf_read_done = 1'b1;
        tick();
        buf_read_done = 1'b0;
        total++; if (req_done !== 3'b000 || busy !== 1'b0) begin bad++; $display("FAIL midrst_stale_done: got done=%b busy=%0b want 000/0", req_done, busy); end
        total++; if (req_data[2] !== exp_data[2]) begin bad++; $display("FAIL midrst_stale_data: got %h want %h", req_data[2], exp_data[2]); end
        req_en = 3'b111;
        tick();
        total++; if (grant !== 3'b001 || buf_read_id !== 5'd11) begin bad++; $display("FAIL midrst_restart: got grant=%b id=%0d want 001/11", grant, buf_read_id); end
        $display("reset_mid_read: restart granted req 0");
        buf_read_done = 1'b1;
        tick();
        buf_read_done = 1'b0;
        req_en        = 3'b000;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_abandon();
        test_spurious();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
